regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Round-robin arbiter that shares the single read port and single write port of `register_file` among NUM_REQ execution units (branch, data-processing, load/store, debug). Each unit requests ownership, receives a registered grant, and drives the register file through the arbiter for as long as it holds the grant. Read data is broadcast, and a per-requester valid pulse marks the returning read for the unit that issued it.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MAX_HOLD, 16, grant-hold limit in cycles (used only with REGFILE_ARB_TIMEOUT_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  ownership request per requester, level, held while ownership is needed
- gnt  out  NUM_REQ  one-hot (or zero) registered grant
- rq_write_en  in  NUM_REQ  per-requester write enable
- rq_write_reg  in  4*NUM_REQ  per-requester write index, requester i at [4i+3:4i]
- rq_write_value  in  32*NUM_REQ  per-requester write data
- rq_read_en  in  NUM_REQ  per-requester read enable
- rq_read_reg  in  4*NUM_REQ  per-requester read index
- rd_valid  out  NUM_REQ  registered one-cycle pulse, read data valid for requester i
- rd_value  out  32  broadcast read data, equals rf_read_value
- rf_write_en / rf_write_reg / rf_write_value  out  1/4/32  to register file write port
- rf_read_en / rf_read_reg  out  1/4  to register file read port
- rf_read_value  in  32  from register file, valid the cycle after rf_read_en is sampled
- busy  out  1  high while any gnt bit is set
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- States: IDLE (gnt=0) and OWN (exactly one gnt bit set). `owner` register holds the index of the granted requester. `last` register holds the most recent owner.
- IDLE: if any req bit is set, select the first set bit searching last+1, last+2, … modulo NUM_REQ. At that edge, set gnt, set `owner` and `last`, and go to OWN.
- OWN: if req[owner]=1, stay. If req[owner]=0, at that edge either pick the next requester by the same search with no bubble cycle, or go to IDLE if none is pending.
- rf_* outputs are a combinational mux of the owner's rq_* signals, ANDed with busy. Enables from non-owners are ignored and dropped, never queued.
- A read accepted in cycle t sets `rd_owner` := owner. In cycle t+1, rd_valid[rd_owner]=1 and rd_value carries the data. This holds even if ownership changes at edge t.
- Owner requests ownership and issues its read/write in the same cycle: allowed.
- Simultaneous write and read of the same register follow the register file's own behaviour. The arbiter adds nothing.

## Timing
- Reset values: gnt=0, state IDLE, last=NUM_REQ-1 (requester 0 wins first), rd_valid=0, timeout=0, hold counter=0. rf_* enables are 0 during reset because gnt clears asynchronously.
- Grant latency: req rising in cycle t with the arbiter idle gives gnt in cycle t+1. The requester may drive rq_* starting in cycle t+1.
- Release: the owner's req low at edge t gives the new owner's gnt in cycle t+1.
- Read latency through the arbiter: 1 cycle, rf_read_en at t gives rd_valid at t+1.
- Reset mid-ownership: grant is lost immediately. A pending rd_valid is cleared. After release of rst_n, the requester must wait for gnt again.

## Configuration
- REGFILE_ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter resets on each new grant and increments every OWN cycle.
  - When the counter reaches MAX_HOLD-1 and another req bit is set, at that edge the grant passes to the next requester and timeout pulses for one cycle.
  - The revoked requester is masked from arbitration until its req goes low.
- Not defined: no counter, timeout tied to 0, grant is held indefinitely while req stays high.

## Test plan
- Reset, then req=4'b0001 → gnt=4'b0001 one cycle later. Write R15=0x1000 through port 0, then read R15 → rd_valid[0] one cycle after rf_read_en, rd_value=0x00001000.
- req=4'b1111 held, each owner releases after 2 cycles → grant order 0,1,2,3,0, no idle cycle between owners.
- Requester 2 owns the port, requester 1 asserts rq_write_en to R14 with 0xDEAD → rf_write_en stays 0 and R14 is unchanged.
- Owner 0 issues a read of R14 and drops req at the same edge, requester 3 is pending → gnt=4'b1000 next cycle, and rd_valid[0] (not rd_valid[3]) pulses with the R14 value.
- rst_n pulled low while owner 1 has a read in flight → gnt=0, rd_valid=0, rf_read_en=0 immediately. After reset, req=4'b0010 is granted again in 1 cycle.
- With REGFILE_ARB_TIMEOUT_EN, MAX_HOLD=16: requester 0 holds req, requester 1 asserts → after 16 OWN cycles, timeout pulses once and gnt=4'b0010. Requester 0 is not regranted until its req toggles low. Without the macro, gnt stays 4'b0001 and timeout=0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of the register file read/write ports among NUM_REQ units.
// Define REGFILE_ARB_TIMEOUT_EN to revoke a grant held MAX_HOLD cycles while others wait.
module regfile_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    input  logic [NUM_REQ-1:0]      rq_write_en,
    input  logic [4*NUM_REQ-1:0]    rq_write_reg,
    input  logic [32*NUM_REQ-1:0]   rq_write_value,
    input  logic [NUM_REQ-1:0]      rq_read_en,
    input  logic [4*NUM_REQ-1:0]    rq_read_reg,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [31:0]             rd_value,
    output logic                    rf_write_en,
    output logic [3:0]              rf_write_reg,
    output logic [31:0]             rf_write_value,
    output logic                    rf_read_en,
    output logic [3:0]              rf_read_reg,
    input  logic [31:0]             rf_read_value,
    output logic                    busy,
    output logic                    timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 256) begin : g_bad_param
        $error("regfile_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, OWN} state_t;
    state_t state;
    logic [IW-1:0] owner, last, pick;
    logic [NUM_REQ-1:0] elig;
    logic found, expire, switch_now;

`ifdef REGFILE_ARB_TIMEOUT_EN
    logic [7:0] hold;
    logic [NUM_REQ-1:0] mask;
    // The current owner is never a candidate, so a timeout always hands off to someone else.
    assign elig = req & ~mask & ~gnt;
    assign expire = state == OWN && hold >= 8'(MAX_HOLD - 1) && found;
`else
    assign elig = req & ~gnt;
    assign expire = 1'b0;
`endif

    always_comb begin
        found = 1'b0;
        pick = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && elig[IW'((int'(last) + k) % NUM_REQ)]) begin
                found = 1'b1;
                pick = IW'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    assign busy = |gnt;
    assign switch_now = state == IDLE || !req[owner] || expire;

    assign rf_write_en    = busy & rq_write_en[owner];
    assign rf_write_reg   = busy ? rq_write_reg[4*owner +: 4] : '0;
    assign rf_write_value = busy ? rq_write_value[32*owner +: 32] : '0;
    assign rf_read_en     = busy & rq_read_en[owner];
    assign rf_read_reg    = busy ? rq_read_reg[4*owner +: 4] : '0;
    assign rd_value       = rf_read_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last     <= IW'(NUM_REQ - 1);
            rd_valid <= '0;
            timeout  <= 1'b0;
`ifdef REGFILE_ARB_TIMEOUT_EN
            hold     <= '0;
            mask     <= '0;
`endif
        end else begin
            // Read tag is the owner at acceptance, independent of any handoff at the same edge.
            rd_valid <= rf_read_en ? ONE << owner : '0;
            timeout  <= expire;
`ifdef REGFILE_ARB_TIMEOUT_EN
            mask     <= (mask & req) | (expire ? gnt : '0);
            hold     <= switch_now ? 8'd0 : (hold == 8'hFF ? hold : hold + 8'd1);
`endif
            if (switch_now) begin
                state <= found ? OWN : IDLE;
                gnt   <= found ? ONE << pick : '0;
                if (found) begin
                    owner <= pick;
                    last  <= pick;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed stimulus with a read-response scoreboard for regfile_arbiter.
// Expected grant values adapt to whether REGFILE_ARB_TIMEOUT_EN is defined.
module tb_regfile_arbiter;
    localparam int N = 4;
`ifdef REGFILE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk, rst_n;
    logic [N-1:0]    req, gnt, rq_write_en, rq_read_en, rd_valid;
    logic [4*N-1:0]  rq_write_reg, rq_read_reg;
    logic [32*N-1:0] rq_write_value;
    logic [31:0]     rd_value, rf_write_value, rf_read_value;
    logic            rf_write_en, rf_read_en, busy, timeout;
    logic [3:0]      rf_write_reg, rf_read_reg;

    regfile_arbiter #(.NUM_REQ(N), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .rq_write_en(rq_write_en), .rq_write_reg(rq_write_reg), .rq_write_value(rq_write_value),
        .rq_read_en(rq_read_en), .rq_read_reg(rq_read_reg),
        .rd_valid(rd_valid), .rd_value(rd_value),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value),
        .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value),
        .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: synchronous write, read data valid the cycle after the read is sampled.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rf_write_en) mem[rf_write_reg] <= rf_write_value;
        if (rf_read_en) rf_read_value <= mem[rf_read_reg];
    end

    typedef struct packed {logic [N-1:0] v; logic [31:0] d;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int i, input logic en, input logic [3:0] r, input logic [31:0] v);
        rq_write_en[i] = en;
        rq_write_reg[4*i +: 4] = r;
        rq_write_value[32*i +: 32] = v;
    endtask

    task automatic set_rd(input int i, input logic en, input logic [3:0] r);
        rq_read_en[i] = en;
        rq_read_reg[4*i +: 4] = r;
    endtask

    task automatic expect_rd(input int i, input logic [31:0] d);
        exp_t e;
        e.v = N'(1 << i);
        e.d = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rd_valid != '0) begin
            if (sb.size() == 0) check("rd_unexpected", 32'(rd_valid), 32'd0);
            else begin
                mon_e = sb.pop_front();
                check("rd_valid", 32'(rd_valid), 32'(mon_e.v));
                check("rd_value", rd_value, mon_e.d);
            end
        end
    end

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0;
        req = '0;
        rq_write_en = '0;
        rq_write_reg = '0;
        rq_write_value = '0;
        rq_read_en = '0;
        rq_read_reg = '0;
        cyc(2);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_rf_en", 32'({rf_write_en, rf_read_en}), 0);
        rst_n = 1'b1;
        // Grant, write and read back through port 0
        req = 4'b0001;
        cyc(1);
        check("grant0", 32'(gnt), 1);
        set_wr(0, 1'b1, 4'd15, 32'h0000_1000);
        #1;
        check("wr_mux_en", 32'(rf_write_en), 1);
        check("wr_mux_reg", 32'(rf_write_reg), 15);
        check("wr_mux_val", rf_write_value, 32'h0000_1000);
        cyc(1);
        set_wr(0, 1'b1, 4'd14, 32'h1414_1414);
        cyc(1);
        set_wr(0, 1'b0, 4'd0, 32'd0);
        set_rd(0, 1'b1, 4'd15);
        expect_rd(0, 32'h0000_1000);
        cyc(1);
        set_rd(0, 1'b0, 4'd0);
        // Round robin with back-to-back handoffs
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            check("rr_hold", 32'(gnt), 32'(1 << order[k]));
            cyc(1);
            check("rr_hold2", 32'(gnt), 32'(1 << order[k]));
            req[order[k]] = 1'b0;
            cyc(1);
            req[order[k]] = 1'b1;
            check("rr_next", 32'(gnt), 32'(1 << order[k+1]));
            check("rr_busy", 32'(busy), 1);
        end
        // Non-owner write is dropped
        req = 4'b0100;
        cyc(1);
        check("own2", 32'(gnt), 32'b0100);
        set_wr(1, 1'b1, 4'd14, 32'h0000_DEAD);
        #1;
        check("nonowner_wr_en", 32'(rf_write_en), 0);
        cyc(1);
        set_wr(1, 1'b0, 4'd0, 32'd0);
        // Read issued at the handoff edge is tagged for the old owner
        req = 4'b0001;
        cyc(1);
        check("own0", 32'(gnt), 1);
        req = 4'b1000;
        set_rd(0, 1'b1, 4'd14);
        expect_rd(0, 32'h1414_1414);
        #1;
        check("rd_mux_en", 32'(rf_read_en), 1);
        check("rd_mux_reg", 32'(rf_read_reg), 14);
        cyc(1);
        set_rd(0, 1'b0, 4'd0);
        check("handoff3", 32'(gnt), 32'b1000);
        // Reset while a read is in flight
        req = 4'b0010;
        cyc(1);
        check("own1", 32'(gnt), 32'b0010);
        set_rd(1, 1'b1, 4'd15);
        cyc(1);
        rst_n = 1'b0;
        #1;
        check("rst_gnt_async", 32'(gnt), 0);
        check("rst_rdv_async", 32'(rd_valid), 0);
        check("rst_rf_rd_en", 32'(rf_read_en), 0);
        cyc(1);
        rst_n = 1'b1;
        set_rd(1, 1'b0, 4'd0);
        check("post_rst_wait", 32'(gnt), 0);
        cyc(1);
        check("regrant1", 32'(gnt), 32'b0010);
        // Hold timeout
        req = '0;
        cyc(1);
        check("idle", 32'(gnt), 0);
        req = 4'b0001;
        cyc(1);
        check("to_grant0", 32'(gnt), 1);
        req = 4'b0011;
        cyc(15);
        check("to_hold", 32'(gnt), 1);
        check("to_quiet", 32'(timeout), 0);
        cyc(1);
        check("to_gnt", 32'(gnt), TO_EN ? 32'b0010 : 32'b0001);
        check("to_pulse", 32'(timeout), 32'(TO_EN));
        cyc(1);
        check("to_pulse_once", 32'(timeout), 0);
        check("to_keep", 32'(gnt), TO_EN ? 32'b0010 : 32'b0001);
        req = 4'b0001;
        cyc(1);
        check("to_masked", 32'(gnt), TO_EN ? 32'b0000 : 32'b0001);
        req = '0;
        cyc(1);
        req = 4'b0001;
        cyc(1);
        check("to_regrant0", 32'(gnt), 1);
        req = '0;
        cyc(3);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
